// File: rtl/vpg_seq_pkg.sv
// rtl/vpg_seq_pkg.sv - shared types and helpers for the video-mode sequencer
// Contents:
//   vpg_state_e : sequencer FSM states
//   vpg_mode_e  : video mode codes driven on mode[3:0]
//   cnt_width   : bit width needed to hold 0..max_val
package vpg_seq_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_KICK,
    ST_SETTLE,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_ERROR
  } vpg_state_e;

  typedef enum logic [3:0] {
    MODE_640x480   = 4'd0,
    MODE_720x480   = 4'd1,
    MODE_1024x768  = 4'd2,
    MODE_1280x1024 = 4'd3,
    MODE_800x480   = 4'd4
  } vpg_mode_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vpg_mode_debounce.sv
// rtl/vpg_mode_debounce.sv - debounces the raw mode request into an accept strobe
// Ports:
//   clk_50, reset : clock, asynchronous active-high reset
//   en            : 1 = debouncer running; 0 = counter held at 0, cand held
//   mode_req[3:0] : raw (bouncing) requested mode
//   mode[3:0]     : currently applied mode; a candidate equal to it is never accepted
//   cand[3:0]     : current debounce candidate
//   accept        : combinational strobe, cand has been stable long enough and differs from mode
module vpg_mode_debounce
  import vpg_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] mode_req,
  input  logic [3:0] mode,
  output logic [3:0] cand,
  output logic       accept
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (mode_req != cand_q) begin
      cand_d = mode_req;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // The edge that sees the D-th consecutive matching sample accepts.
  assign accept = en && (mode_req == cand_q) && (cnt_q == CNT_LAST) && (cand_q != mode);
  assign cand   = cand_q;

endmodule

// File: rtl/vpg_mode_sequencer.sv
// rtl/vpg_mode_sequencer.sv - sequences video mode changes around pixel PLL relock
// Ports:
//   clk_50             : 50 MHz management clock
//   reset              : asynchronous active-high reset
//   mode_req[3:0]      : requested mode from switches (asynchronous, bouncing)
//   pll_locked         : pixel PLL lock (asynchronous)
//   mode[3:0]          : applied mode code
//   mode_change        : one-cycle pulse, mode valid on the same cycle
//   gen_enable         : 1 = timing generator may run
//   busy               : 1 whenever not in RUN
//   lock_err           : 1 while in ERROR (PLL failed to lock in time)
//   lock_loss_cnt[7:0] : saturating count of lock drops seen in RUN
module vpg_mode_sequencer
  import vpg_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RECONF_WAIT     = 1024,
  parameter int LOCK_STABLE     = 4096,
  parameter int LOCK_TIMEOUT    = 5000000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [3:0] mode_req,
  input  logic       pll_locked,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic       gen_enable,
  output logic       busy,
  output logic       lock_err,
  output logic [7:0] lock_loss_cnt
);

  localparam int SW = cnt_width(RECONF_WAIT);
  localparam int LW = cnt_width(LOCK_STABLE);
  localparam int TW = cnt_width(LOCK_TIMEOUT);
  localparam logic [SW-1:0] SETTLE_END = SW'(RECONF_WAIT);
  localparam logic [LW-1:0] STABLE_END = LW'(LOCK_STABLE);
  localparam logic [TW-1:0] TIMEOUT_END = TW'(LOCK_TIMEOUT);

  vpg_state_e    state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [3:0]    mode_q, mode_d;
  logic          mode_change_q, mode_change_d;
  logic          gen_enable_q, gen_enable_d;
  logic          busy_q, busy_d;
  logic          lock_err_q, lock_err_d;
  logic [7:0]    loss_q, loss_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [LW-1:0] stable_q, stable_d;
  logic [TW-1:0] timeout_q, timeout_d;

  logic       locked_s;
  logic       deb_en;
  logic       deb_accept;
  logic [3:0] deb_cand;

  assign locked_s = sync_q[1];
  assign deb_en   = (state_q == ST_RUN) || (state_q == ST_ERROR);

  vpg_mode_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_50  (clk_50),
    .reset   (reset),
    .en      (deb_en),
    .mode_req(mode_req),
    .mode    (mode_q),
    .cand    (deb_cand),
    .accept  (deb_accept)
  );

  always_comb begin
    sync_d    = {sync_q[0], pll_locked};
    state_d   = state_q;
    mode_d    = mode_q;
    loss_d    = loss_q;
    timeout_d = timeout_q;
    settle_d  = '0;
    stable_d  = '0;

    case (state_q)
      ST_START: begin
        // Power-up mode is taken straight from the switches, no debounce.
        mode_d  = mode_req;
        state_d = ST_KICK;
      end
      ST_KICK: begin
        timeout_d = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timeout_q != TIMEOUT_END) timeout_d = timeout_q + 1'b1;
        if (timeout_q == TIMEOUT_END) begin
          state_d = ST_ERROR;
        end else if (settle_q == SETTLE_END) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (timeout_q != TIMEOUT_END) timeout_d = timeout_q + 1'b1;
        // Timeout wins over a stable count completing on the same edge.
        if (timeout_q == TIMEOUT_END) begin
          state_d = ST_ERROR;
        end else if (stable_q == STABLE_END) begin
          state_d = ST_RUN;
        end else if (locked_s) begin
          stable_d = stable_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Lock loss beats a pending mode request; relock without re-kicking the PLL.
        if (!locked_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          timeout_d = '0;
          state_d   = ST_WAIT_LOCK;
        end else if (deb_accept) begin
          mode_d  = deb_cand;
          state_d = ST_KICK;
        end
      end
      ST_ERROR: begin
        if (deb_accept) begin
          mode_d  = deb_cand;
          state_d = ST_KICK;
        end
      end
      default: state_d = ST_START;
    endcase

    // Outputs are registered decodes of the next state.
    mode_change_d = (state_d == ST_KICK);
    gen_enable_d  = (state_d == ST_RUN);
    busy_d        = (state_d != ST_RUN);
    lock_err_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_START;
      sync_q        <= '0;
      mode_q        <= MODE_640x480;
      mode_change_q <= 1'b0;
      gen_enable_q  <= 1'b0;
      busy_q        <= 1'b1;
      lock_err_q    <= 1'b0;
      loss_q        <= '0;
      settle_q      <= '0;
      stable_q      <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      gen_enable_q  <= gen_enable_d;
      busy_q        <= busy_d;
      lock_err_q    <= lock_err_d;
      loss_q        <= loss_d;
      settle_q      <= settle_d;
      stable_q      <= stable_d;
      timeout_q     <= timeout_d;
    end
  end

  assign mode          = mode_q;
  assign mode_change   = mode_change_q;
  assign gen_enable    = gen_enable_q;
  assign busy          = busy_q;
  assign lock_err      = lock_err_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// tb/tb_vpg_mode_sequencer.sv - self-checking bench for vpg_mode_sequencer
module tb_vpg_mode_sequencer;

  localparam int D  = 8;
  localparam int RW = 4;
  localparam int LS = 16;
  localparam int LT = 200;
  localparam int LOCK_LAT  = 1 + RW + LS + 2;
  localparam int GLITCH_AT = 2 + RW + 10;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mode_req = 4'd0;
  logic       pll_locked = 1'b0;
  logic [3:0] mode;
  logic       mode_change;
  logic       gen_enable;
  logic       busy;
  logic       lock_err;
  logic [7:0] lock_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int mc_count = 0;
  int exp_loss = 0;
  logic [3:0] exp_mode;

  vpg_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .RECONF_WAIT(RW),
    .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .mode_req     (mode_req),
    .pll_locked   (pll_locked),
    .mode         (mode),
    .mode_change  (mode_change),
    .gen_enable   (gen_enable),
    .busy         (busy),
    .lock_err     (lock_err),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
    if (mode_change === 1'b1) mc_count++;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return mode_change;
      1:       return gen_enable;
      2:       return lock_err;
      default: return busy;
    endcase
  endfunction

  // Edges until the selected output reaches val; -1 if the budget runs out.
  task automatic wait_sig(input int sel, input logic val, output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (sig(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [3:0] other_mode(input logic [3:0] cur);
    logic [3:0] m;
    m = cur;
    while (m == cur) m = 4'($urandom_range(0, 4));
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_mode_change"}, mode_change, 0);
    check({tag, "_gen_enable"}, gen_enable, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_lock_err"}, lock_err, 0);
    check({tag, "_loss"}, lock_loss_cnt, 0);
  endtask

  task automatic pulse_lock_low();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
  endtask

  initial begin
    int n;
    int mc0;
    logic [3:0] m, q, v, prev;

    // Reset values and power-up apply.
    repeat (2) tick();
    check_reset_outputs("rst");
    mode_req   = 4'd2;
    pll_locked = 1'b1;
    reset      = 1'b0;
    wait_sig(0, 1'b1, n);
    check("start_kick_edges", n, 1);
    check("start_mode", mode, 2);
    exp_mode = 4'd2;
    wait_sig(1, 1'b1, n);
    check("start_lock_edges", n, LOCK_LAT);
    check("start_busy", busy, 0);

    // Randomized requests with bounce, some arriving while busy.
    for (int r = 0; r < 4; r++) begin
      repeat (3) tick();
      m    = other_mode(exp_mode);
      mc0  = mc_count;
      prev = mode_req;
      for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
        do v = 4'($urandom_range(0, 15)); while (v == prev || v == m);
        mode_req = v;
        prev     = v;
        repeat ($urandom_range(1, D - 1)) tick();
      end
      mode_req = m;
      wait_sig(0, 1'b1, n);
      check("accept_edges", n, D + 1);
      check("accept_mode", mode, m);
      check("accept_gen_low", gen_enable, 0);
      check("bounce_no_accept", mc_count - mc0, 1);
      exp_mode = m;
      q = ($urandom_range(0, 1) == 1) ? other_mode(m) : m;
      mode_req = q;
      wait_sig(1, 1'b1, n);
      check("relock_edges", n, LOCK_LAT);
      check("busy_req_ignored", mode, exp_mode);
      if (q != m) begin
        wait_sig(0, 1'b1, n);
        check("rebounce_edges", n, D + 1);
        check("rebounce_mode", mode, q);
        exp_mode = q;
        wait_sig(1, 1'b1, n);
        check("rebounce_lock_edges", n, LOCK_LAT);
      end
    end

    // Short toggle 4 -> 0 -> 4 restarts the debounce window.
    repeat (3) tick();
    mode_req = (exp_mode == 4'd4) ? 4'd1 : 4'd4;
    m        = mode_req;
    repeat (3) tick();
    mode_req = (m == 4'd0) ? 4'd3 : 4'd0;
    repeat (2) tick();
    mode_req = m;
    wait_sig(0, 1'b1, n);
    check("toggle_accept_edges", n, D + 1);
    check("toggle_mode", mode, m);
    exp_mode = m;

    // One-cycle lock glitch after 10 stable counts in WAIT_LOCK.
    repeat (GLITCH_AT) tick();
    check("glitch_gen_low", gen_enable, 0);
    pulse_lock_low();
    wait_sig(1, 1'b1, n);
    check("glitch_relock_edges", n, 3 + LS);

    // Lock drops in RUN.
    repeat (3) tick();
    mc0 = mc_count;
    for (int i = 0; i < 3; i++) begin
      pulse_lock_low();
      wait_sig(1, 1'b0, n);
      check("loss_fall_edges", n + 1, 3);
      wait_sig(1, 1'b1, n);
      check("loss_relock_edges", n, LS + 1);
      exp_loss++;
      check("loss_count", lock_loss_cnt, exp_loss);
    end
    check("loss_no_kick", mc_count - mc0, 0);
    check("loss_mode_kept", mode, exp_mode);
    for (int i = 0; i < 297; i++) begin
      pulse_lock_low();
      wait_sig(1, 1'b0, n);
      wait_sig(1, 1'b1, n);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
    end
    check("loss_saturated", lock_loss_cnt, exp_loss);

    // Lock never returns: timeout into ERROR, then exit on a new request.
    repeat (3) tick();
    m = other_mode(exp_mode);
    mode_req = m;
    wait_sig(0, 1'b1, n);
    check("to_accept_edges", n, D + 1);
    exp_mode   = m;
    pll_locked = 1'b0;
    wait_sig(2, 1'b1, n);
    check("timeout_edges", n, LT + 2);
    check("err_gen_low", gen_enable, 0);
    check("err_busy", busy, 1);
    m = other_mode(exp_mode);
    mode_req   = m;
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, n);
    check("err_exit_edges", n, D + 1);
    check("err_exit_lock_err", lock_err, 0);
    check("err_exit_mode", mode, m);
    exp_mode = m;
    wait_sig(1, 1'b1, n);
    check("err_relock_edges", n, LOCK_LAT);

    // Asynchronous reset during SETTLE.
    repeat (3) tick();
    mode_req = other_mode(exp_mode);
    wait_sig(0, 1'b1, n);
    check("pre_reset_accept", n, D + 1);
    repeat (2) tick();
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    m = other_mode(4'd0);
    mode_req = m;
    tick();
    reset = 1'b0;
    wait_sig(0, 1'b1, n);
    check("restart_kick_edges", n, 1);
    check("restart_mode", mode, m);
    wait_sig(1, 1'b1, n);
    check("restart_lock_edges", n, LOCK_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
